// File: rtl/hpdmc_cmdsched.sv
// hpdmc_cmdsched: SDRAM command scheduler with an open-page policy.
// Takes one access request at a time (stb/we/address) and turns it into
// ACT / READ / WRITE / PRE sequences, and interleaves auto-refresh
// (PRE-all + REF) driven by a free-running refresh interval timer.
// Ports:
//   sys_clk, sdram_rst      - clock, synchronous active-high reset
//   stb, we, address        - request {bank[21:20], row[19:7], col[6:0]}
//   ack_cmd                 - pulse when the request's READ/WRITE goes out
//   sdram_*                 - registered SDRAM command, address, bank
//   read, write, concerned_bank - data controller notifications
//   read_safe, write_safe, precharge_safe - data controller interlocks
//   tim_*                   - timing parameters in cycles
module hpdmc_cmdsched (
  input  logic        sys_clk,
  input  logic        sdram_rst,
  input  logic        stb,
  input  logic        we,
  input  logic [21:0] address,
  output logic        ack_cmd,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [12:0] sdram_adr,
  output logic [1:0]  sdram_ba,
  output logic        read,
  output logic        write,
  output logic [3:0]  concerned_bank,
  input  logic        read_safe,
  input  logic        write_safe,
  input  logic [3:0]  precharge_safe,
  input  logic [2:0]  tim_rp,
  input  logic [2:0]  tim_rcd,
  input  logic [3:0]  tim_rfc,
  input  logic [10:0] tim_refi
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;

  typedef enum logic [3:0] {
    S_IDLE, S_ACT, S_WAIT_RCD, S_RW, S_PRE, S_WAIT_RP, S_PREALL, S_REF, S_WAIT_RFC
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             rp_to_ref_q, rp_to_ref_d;   // WAIT_RP exits to REF after a PRE-all
  logic [10:0]      refi_q, refi_d;
  logic             ref_pend_q, ref_pend_d;
  logic [3:0]       open_q, open_d;
  logic [3:0][12:0] row_q, row_d;
  logic             rq_we_q, rq_we_d;
  logic [1:0]       rq_bank_q, rq_bank_d;
  logic [12:0]      rq_row_q, rq_row_d;
  logic [6:0]       rq_col_q, rq_col_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [12:0]      adr_q, adr_d;
  logic [1:0]       ba_q, ba_d;
  logic             ack_q, ack_d, rd_q, rd_d, wr_q, wr_d;
  logic [3:0]       cb_q, cb_d;

  logic [1:0]  in_bank;
  logic [12:0] in_row;
  logic [2:0]  rp_eff, rcd_eff;
  logic        refi_expire, rw_go, pre_go, preall_go;

  assign in_bank     = address[21:20];
  assign in_row      = address[19:7];
  assign rp_eff      = (tim_rp  == 3'd0) ? 3'd1 : tim_rp;
  assign rcd_eff     = (tim_rcd == 3'd0) ? 3'd1 : tim_rcd;
  assign refi_expire = (refi_q == 11'd0);
  assign rw_go       = rq_we_q ? write_safe : read_safe;
  assign pre_go      = precharge_safe[rq_bank_q];
  assign preall_go   = (open_q != 4'd0) && (&precharge_safe);

  // State and all registers.
  always_ff @(posedge sys_clk) begin
    if (sdram_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rp_to_ref_q <= 1'b0;
      refi_q      <= tim_refi;
      ref_pend_q  <= 1'b0;
      open_q      <= '0;
      row_q       <= '0;
      rq_we_q     <= 1'b0;
      rq_bank_q   <= '0;
      rq_row_q    <= '0;
      rq_col_q    <= '0;
      cmd_q       <= CMD_NOP;
      adr_q       <= '0;
      ba_q        <= '0;
      ack_q       <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      cb_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rp_to_ref_q <= rp_to_ref_d;
      refi_q      <= refi_d;
      ref_pend_q  <= ref_pend_d;
      open_q      <= open_d;
      row_q       <= row_d;
      rq_we_q     <= rq_we_d;
      rq_bank_q   <= rq_bank_d;
      rq_row_q    <= rq_row_d;
      rq_col_q    <= rq_col_d;
      cmd_q       <= cmd_d;
      adr_q       <= adr_d;
      ba_q        <= ba_d;
      ack_q       <= ack_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      cb_q        <= cb_d;
    end
  end

  // Next state, counters, bank bookkeeping.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rp_to_ref_d = rp_to_ref_q;
    open_d      = open_q;
    row_d       = row_q;
    rq_we_d     = rq_we_q;
    rq_bank_d   = rq_bank_q;
    rq_row_d    = rq_row_q;
    rq_col_d    = rq_col_q;
    refi_d      = refi_expire ? tim_refi : refi_q - 11'd1;
    // Single pending bit: an expiry while already pending is absorbed.
    ref_pend_d  = refi_expire | (ref_pend_q & (state_q != S_REF));
    case (state_q)
      S_IDLE: begin
        if (ref_pend_q) begin
          state_d = S_PREALL;
        // ack_cmd is registered, so stb is still high during the ack cycle;
        // ignore it then to avoid re-accepting the finished request.
        end else if (stb && !ack_q) begin
          rq_we_d   = we;
          rq_bank_d = in_bank;
          rq_row_d  = in_row;
          rq_col_d  = address[6:0];
          if (!open_q[in_bank])              state_d = S_ACT;
          else if (row_q[in_bank] == in_row) state_d = S_RW;
          else                               state_d = S_PRE;
        end
      end
      S_ACT: begin
        open_d[rq_bank_q] = 1'b1;
        row_d[rq_bank_q]  = rq_row_q;
        // The ACT itself occupies one cycle, so only rcd-1 wait cycles remain.
        cnt_d   = {1'b0, rcd_eff} - 4'd1;
        state_d = (rcd_eff == 3'd1) ? S_RW : S_WAIT_RCD;
      end
      S_WAIT_RCD: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RW;
      end
      S_RW:
        if (rw_go) state_d = S_IDLE;
      S_PRE:
        if (pre_go) begin
          open_d[rq_bank_q] = 1'b0;
          rp_to_ref_d       = 1'b0;
          cnt_d             = {1'b0, rp_eff} - 4'd1;
          state_d           = (rp_eff == 3'd1) ? S_ACT : S_WAIT_RP;
        end
      S_WAIT_RP: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = rp_to_ref_q ? S_REF : S_ACT;
      end
      S_PREALL: begin
        if (open_q == 4'd0) begin
          state_d = S_REF;
        end else if (preall_go) begin
          open_d      = '0;
          rp_to_ref_d = 1'b1;
          cnt_d       = {1'b0, rp_eff} - 4'd1;
          state_d     = (rp_eff == 3'd1) ? S_REF : S_WAIT_RP;
        end
      end
      S_REF: begin
        cnt_d   = tim_rfc;
        state_d = S_WAIT_RFC;
      end
      S_WAIT_RFC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command / notification outputs; address and bank hold on NOP cycles.
  always_comb begin
    cmd_d = CMD_NOP;
    adr_d = adr_q;
    ba_d  = ba_q;
    ack_d = 1'b0;
    rd_d  = 1'b0;
    wr_d  = 1'b0;
    cb_d  = '0;
    case (state_q)
      S_ACT: begin
        cmd_d = CMD_ACT;
        ba_d  = rq_bank_q;
        adr_d = rq_row_q;
      end
      S_RW:
        if (rw_go) begin
          cmd_d = rq_we_q ? CMD_WR : CMD_RD;
          ba_d  = rq_bank_q;
          adr_d = {4'b0000, rq_col_q, 2'b00};
          ack_d = 1'b1;
          rd_d  = ~rq_we_q;
          wr_d  = rq_we_q;
          cb_d  = 4'(4'b0001 << rq_bank_q);
        end
      S_PRE:
        if (pre_go) begin
          cmd_d = CMD_PRE;
          ba_d  = rq_bank_q;
          adr_d = 13'h0000;
        end
      S_PREALL:
        if (preall_go) begin
          cmd_d = CMD_PRE;
          adr_d = 13'h0400;
        end
      S_REF: cmd_d = CMD_REF;
      default: ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;
  assign sdram_adr      = adr_q;
  assign sdram_ba       = ba_q;
  assign ack_cmd        = ack_q;
  assign read           = rd_q;
  assign write          = wr_q;
  assign concerned_bank = cb_q;

endmodule

// File: doc/hpdmc_cmdsched.md
HPDMC_CMDSCHED -- requirements
Module: hpdmc_cmdsched

Interface
REQ-001 SHALL have port sys_clk, input, 1, single system clock; all logic is on its rising edge.
REQ-002 SHALL have port sdram_rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port stb, input, 1, access request valid; held until ack_cmd.
REQ-004 SHALL have port we, input, 1, 1 = write, 0 = read; sampled with stb.
REQ-005 SHALL have port address, input, 22, fields {bank[21:20], row[19:7], col[6:0]}, where col addresses 4-word bursts.
REQ-006 SHALL have port ack_cmd, output, 1, one-cycle pulse when the request's Read or Write command is issued.
REQ-007 SHALL have ports sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, output, 1 each, registered SDRAM command.
REQ-008 SHALL have port sdram_adr, output, 13, registered SDRAM address; sdram_ba, output, 2, registered bank.
REQ-009 SHALL have ports read and write, output, 1 each, one-cycle pulses to the data controller, coincident with the Read or Write command.
REQ-010 SHALL have port concerned_bank, output, 4, one-hot bank of the current Read or Write, valid with read or write.
REQ-011 SHALL have ports read_safe, write_safe, input, 1 each, and precharge_safe, input, 4, per bank, all from the data controller.
REQ-012 SHALL have ports tim_rp, tim_rcd, input, 3 each, in cycles, 0 treated as 1; tim_rfc, input, 4, cycles; tim_refi, input, 11, refresh interval in cycles.

Function
REQ-013 SHALL encode commands {cs_n,ras_n,cas_n,we_n}: NOP 0111, ACT 0011, READ 0101, WRITE 0100, PRE 0010, REF 0001; SHALL drive NOP on every cycle not issuing a command.
REQ-014 SHALL track per bank an open flag and a 13-bit open row (open-page policy).
REQ-015 SHALL implement states IDLE, ACT, WAIT_RCD, RW, PRE, WAIT_RP, PREALL, REF, WAIT_RFC.
REQ-016 IDLE: if a refresh is pending, go to PREALL; otherwise, if stb is high: bank open with matching row -> RW; bank open with different row -> PRE; bank closed -> ACT.
REQ-017 ACT: issue ACT with ba=bank, adr=row; mark bank open with that row; load the counter with tim_rcd; go to WAIT_RCD.
REQ-018 WAIT_RCD: decrement; at count 1 go to RW (ACT-to-RW spacing = max(tim_rcd,1) cycles).
REQ-019 RW: if we=1 and write_safe=1, issue WRITE; if we=0 and read_safe=1, issue READ; otherwise stall in RW issuing NOP.
REQ-020 On READ/WRITE: adr = {4'b0000, col, 2'b00} (A10=0, no auto-precharge); pulse ack_cmd, read or write, and concerned_bank; return to IDLE.
REQ-021 PRE: wait, issuing NOP, until precharge_safe[bank]=1; then issue PRE with ba=bank, adr[10]=0; clear the open flag; load tim_rp; go to WAIT_RP.
REQ-022 WAIT_RP: count down tim_rp, then go to ACT for the same request.
REQ-023 Refresh timer: counts down from tim_refi. At 0 it sets refresh_pending and reloads. refresh_pending clears when REF is issued. A second expiry while pending SHALL NOT queue a second refresh.
REQ-024 PREALL: if no bank is open, go straight to REF. Otherwise wait for precharge_safe==4'b1111, then issue PRE with adr[10]=1, clear all open flags, count down tim_rp, and go to REF.
REQ-025 REF: issue REF; load tim_rfc; go to WAIT_RFC; return to IDLE when the count expires.
REQ-026 Refresh SHALL take priority over stb only in IDLE; a request already past IDLE completes first.
REQ-027 At most one command SHALL be issued per cycle; ack_cmd SHALL pulse exactly once per accepted request.
REQ-028 stb deasserted mid-sequence (a protocol violation) SHALL still complete the sequence without hanging.

Reset
REQ-029 While sdram_rst=1: state IDLE, command NOP (1111 with cs_n=1 allowed only in reset), adr=0, ba=0, ack_cmd/read/write=0, concerned_bank=0, all banks closed, refresh_pending=0, timer loaded with tim_refi.
REQ-030 Reset asserted mid-sequence SHALL abort the sequence within the same cycle; no partial command follows.

Verification
REQ-031 Closed bank, read of bank 2 row 0x155, tim_rcd=2 -> ACT(ba=2, adr=0x155), 2 cycles later READ; concerned_bank=0100; ack_cmd pulses once.
REQ-032 Same row, repeat write, write_safe=0 for 3 cycles -> no ACT; WRITE issued on the first cycle after write_safe=1.
REQ-033 Row miss on open bank 1, precharge_safe[1]=0 for 4 cycles -> PRE(adr[10]=0) after safe, tim_rp gap, ACT with the new row, then RW.
REQ-034 tim_refi=100 with banks 0 and 3 open -> PREALL(adr[10]=1), REF after tim_rp, no command for tim_rfc; next access re-ACTs.
REQ-035 stb held during refresh expiry in IDLE -> refresh completes before the ACT; exactly one REF per interval.
REQ-036 sdram_rst pulsed in WAIT_RCD -> NOP next cycle, all banks closed, next request begins with ACT.
